// File: rtl/axi_sched_pkg.sv
// ============================================================================
// Module  : axi_sched_pkg
// Brief   : Shared FSM state encoding, slave indices and default decode bases
//           for the axi_rd_sched read scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

package axi_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DERR = 2'd3
    } state_e;

    localparam logic C_SLV0 = 1'b0;
    localparam logic C_SLV1 = 1'b1;

    localparam logic [15:0] C_S0_BASE_DEF = 16'h0000;
    localparam logic [15:0] C_S1_BASE_DEF = 16'h0001;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-way AR arbiter. Round-robin with a last-grant pointer when
//           AXI_RD_SCHED_RR_EN is defined, else fixed priority (master 1 first).
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
`ifdef AXI_RD_SCHED_RR_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       gnt_en_i,
`endif
    input  logic [1:0] req_i,
    output logic       gnt_idx_o
);

`ifdef AXI_RD_SCHED_RR_EN
    logic last_q;
    logic last_d;

    // On a tie the master not granted last wins; a lone requester always wins.
    always_comb begin
        gnt_idx_o = req_i[1];
        if (&req_i) begin
            gnt_idx_o = ~last_q;
        end
        last_d = gnt_en_i ? gnt_idx_o : last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign gnt_idx_o = req_i[1];
`endif

endmodule

`default_nettype wire

// File: rtl/axi_rd_sched.sv
// ============================================================================
// Module  : axi_rd_sched
// Brief   : 2-master / 2-slave AXI read scheduler with address decode, DECERR
//           response and single outstanding burst. Option: AXI_RD_SCHED_RR_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_rd_sched
    import axi_sched_pkg::*;
#(
    parameter int                   ADDR_HI_W = 16,
    parameter logic [ADDR_HI_W-1:0] S0_BASE   = ADDR_HI_W'(C_S0_BASE_DEF),
    parameter logic [ADDR_HI_W-1:0] S1_BASE   = ADDR_HI_W'(C_S1_BASE_DEF)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           arvalid_m,
    input  logic [ADDR_HI_W-1:0] araddr_hi_m0,
    input  logic [ADDR_HI_W-1:0] araddr_hi_m1,
    input  logic [1:0]           arready_s,
    input  logic [1:0]           rready_m,
    input  logic                 r_last_hs,
    output logic [1:0]           arready_m,
    output logic [1:0]           ar_sel_s,
    output logic                 r_owner,
    output logic                 r_src,
    output logic                 derr_rvalid,
    output logic                 busy
);

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   tgt_q,   tgt_d;
    logic   err_q,   err_d;
    logic   src_q,   src_d;

    logic                 w_gnt_idx;
    logic                 w_grant_en;
    logic [ADDR_HI_W-1:0] w_win_addr;
    logic                 w_hit0;
    logic                 w_hit1;

    assign w_grant_en = (state_q == ST_IDLE) && (|arvalid_m);

    rr_arb2 u_arb (
`ifdef AXI_RD_SCHED_RR_EN
        .clk       (clk),
        .rst       (rst),
        .gnt_en_i  (w_grant_en),
`endif
        .req_i     (arvalid_m),
        .gnt_idx_o (w_gnt_idx)
    );

    // Decode only the winner's address; slave 0 takes precedence if bases alias.
    assign w_win_addr = w_gnt_idx ? araddr_hi_m1 : araddr_hi_m0;
    assign w_hit0     = (w_win_addr == S0_BASE);
    assign w_hit1     = (w_win_addr == S1_BASE);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        tgt_d       = tgt_q;
        err_d       = err_q;
        src_d       = src_q;
        arready_m   = 2'b00;
        ar_sel_s    = 2'b00;
        derr_rvalid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_grant_en) begin
                    owner_d = w_gnt_idx;
                    tgt_d   = w_hit0 ? C_SLV0 : C_SLV1;
                    err_d   = ~(w_hit0 | w_hit1);
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (err_q) begin
                    // Swallow the unmapped address locally, then answer with DECERR.
                    arready_m[owner_q] = 1'b1;
                    state_d            = ST_DERR;
                end else begin
                    ar_sel_s[tgt_q]    = 1'b1;
                    arready_m[owner_q] = arready_s[tgt_q];
                    if (arvalid_m[owner_q] && arready_s[tgt_q]) begin
                        src_d   = tgt_q;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (r_last_hs) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DERR: begin
                derr_rvalid = 1'b1;
                if (rready_m[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            tgt_q   <= 1'b0;
            err_q   <= 1'b0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            tgt_q   <= tgt_d;
            err_q   <= err_d;
            src_q   <= src_d;
        end
    end

    assign r_owner = owner_q;
    assign r_src   = src_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_sched.sv
// ============================================================================
// Module  : tb_axi_rd_sched
// Brief   : Self-checking bench for axi_rd_sched: directed scenarios with literal
//           expectations plus randomized traffic against a transaction model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axi_rd_sched;

    logic        clk;
    logic        rst;
    logic [1:0]  arvalid_m;
    logic [15:0] araddr_hi_m0;
    logic [15:0] araddr_hi_m1;
    logic [1:0]  arready_s;
    logic [1:0]  rready_m;
    logic        r_last_hs;
    logic [1:0]  arready_m;
    logic [1:0]  ar_sel_s;
    logic        r_owner;
    logic        r_src;
    logic        derr_rvalid;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef AXI_RD_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    axi_rd_sched dut (
        .clk          (clk),
        .rst          (rst),
        .arvalid_m    (arvalid_m),
        .araddr_hi_m0 (araddr_hi_m0),
        .araddr_hi_m1 (araddr_hi_m1),
        .arready_s    (arready_s),
        .rready_m     (rready_m),
        .r_last_hs    (r_last_hs),
        .arready_m    (arready_m),
        .ar_sel_s     (ar_sel_s),
        .r_owner      (r_owner),
        .r_src        (r_src),
        .derr_rvalid  (derr_rvalid),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction model: phase of the single outstanding read (0 none,
    // 1 address offered, 2 data streaming, 3 error response pending).
    int m_phase;
    bit m_owner, m_slave, m_unmapped, m_src, m_last_winner;

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_slave = 0; m_unmapped = 0;
        m_src = 0; m_last_winner = 1;
    endtask

    task automatic model_update();
        bit        w;
        bit [15:0] a;
        if (m_phase == 0) begin
            if (arvalid_m != 2'b00) begin
                if (arvalid_m == 2'b01)      w = 0;
                else if (arvalid_m == 2'b10) w = 1;
                else                         w = RR ? !m_last_winner : 1'b1;
                m_last_winner = w;
                m_owner = w;
                a = w ? araddr_hi_m1 : araddr_hi_m0;
                m_unmapped = !(a == 16'h0000 || a == 16'h0001);
                m_slave    = (a == 16'h0000) ? 1'b0 : 1'b1;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (m_unmapped) m_phase = 3;
            else if (arvalid_m[m_owner] && arready_s[m_slave]) begin
                m_src = m_slave;
                m_phase = 2;
            end
        end else if (m_phase == 2) begin
            if (r_last_hs) m_phase = 0;
        end else begin
            if (rready_m[m_owner]) m_phase = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_compare();
        logic [1:0] e_ar, e_sel;
        e_ar = 2'b00; e_sel = 2'b00;
        if (m_phase == 1) begin
            if (m_unmapped) e_ar[m_owner] = 1'b1;
            else begin
                e_sel[m_slave] = 1'b1;
                e_ar[m_owner]  = arready_s[m_slave];
            end
        end
        chk("m_arready_m",   {30'd0, arready_m}, {30'd0, e_ar});
        chk("m_ar_sel_s",    {30'd0, ar_sel_s},  {30'd0, e_sel});
        chk("m_r_owner",     {31'd0, r_owner},   {31'd0, m_owner});
        chk("m_r_src",       {31'd0, r_src},     {31'd0, m_src});
        chk("m_derr_rvalid", {31'd0, derr_rvalid}, {31'd0, (m_phase == 3)});
        chk("m_busy",        {31'd0, busy},      {31'd0, (m_phase != 0)});
    endtask

    // Called at a negedge with inputs applied: check, advance one edge, return at negedge.
    task automatic tick();
        #1;
        model_compare();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] av, input logic [15:0] a0, input logic [15:0] a1,
                         input logic [1:0] ars, input logic [1:0] rr, input logic lh);
        arvalid_m = av; araddr_hi_m0 = a0; araddr_hi_m1 = a1;
        arready_s = ars; rready_m = rr; r_last_hs = lh;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_arready_m", {30'd0, arready_m}, 32'd0);
        chk("rst_ar_sel_s",  {30'd0, ar_sel_s},  32'd0);
        chk("rst_r_owner",   {31'd0, r_owner},   32'd0);
        chk("rst_r_src",     {31'd0, r_src},     32'd0);
        chk("rst_derr",      {31'd0, derr_rvalid}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] atab [0:3];
        atab[0] = 16'h0000; atab[1] = 16'h0001; atab[2] = 16'h0002; atab[3] = 16'hBEEF;
        rst = 1'b0;
        drive(2'b00, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0);
        model_reset();
        @(negedge clk);
        do_reset();

        // Single M0 read to slave 0.
        drive(2'b01, 16'h0000, 16'h0000, 2'b01, 2'b00, 1'b0);
        #1 chk("t1_idle_busy", {31'd0, busy}, 32'd0);
        tick();
        #1 chk("t1_addr_arready", {30'd0, arready_m}, 32'h1);
        chk("t1_addr_sel", {30'd0, ar_sel_s}, 32'h1);
        tick();
        drive(2'b00, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b1);
        #1 chk("t1_data_busy", {31'd0, busy}, 32'd1);
        tick();
        #1 chk("t1_back_idle", {31'd0, busy}, 32'd0);

        // Simultaneous requests to slave 1.
        do_reset();
        drive(2'b11, 16'h0001, 16'h0001, 2'b11, 2'b00, 1'b0);
        tick();
        #1 chk("t2_first_owner", {31'd0, r_owner}, RR ? 32'd0 : 32'd1);
        chk("t2_first_sel", {30'd0, ar_sel_s}, 32'h2);
        tick();
        r_last_hs = 1'b1;
        tick();
        r_last_hs = 1'b0;
        tick();
        #1 chk("t2_second_owner", {31'd0, r_owner}, 32'd1);
        chk("t2_second_arready", {30'd0, arready_m}, 32'h2);
        tick();
        drive(2'b00, 16'h0, 16'h0, 2'b00, 2'b00, 1'b1);
        tick();

        // Unmapped address from M1 gets a DECERR response.
        drive(2'b10, 16'h0000, 16'h0002, 2'b00, 2'b00, 1'b0);
        tick();
        #1 chk("t3_addr_arready", {30'd0, arready_m}, 32'h2);
        chk("t3_addr_sel", {30'd0, ar_sel_s}, 32'h0);
        tick();
        arvalid_m = 2'b00;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t3_derr_hold", {31'd0, derr_rvalid}, 32'd1);
            tick();
        end
        rready_m = 2'b10;
        #1 chk("t3_derr_last", {31'd0, derr_rvalid}, 32'd1);
        tick();
        rready_m = 2'b00;
        #1 chk("t3_derr_drop", {31'd0, derr_rvalid}, 32'd0);
        chk("t3_idle", {31'd0, busy}, 32'd0);

        // Last beat coinciding with a new request leaves a one-cycle bubble.
        drive(2'b01, 16'h0000, 16'h0000, 2'b01, 2'b00, 1'b0);
        tick(); tick();
        r_last_hs = 1'b1;
        tick();
        r_last_hs = 1'b0;
        #1 chk("t4_bubble_busy", {31'd0, busy}, 32'd0);
        chk("t4_bubble_arready", {30'd0, arready_m}, 32'd0);
        tick();
        #1 chk("t4_regrant_arready", {30'd0, arready_m}, 32'h1);
        tick();
        drive(2'b00, 16'h0, 16'h0, 2'b00, 2'b00, 1'b1);
        tick();

        // Reset in the middle of a burst, then arbitration restarts from pointer=1.
        drive(2'b10, 16'h0000, 16'h0001, 2'b10, 2'b00, 1'b0);
        tick(); tick();
        arvalid_m = 2'b00;
        #1 chk("t5_data_src", {31'd0, r_src}, 32'd1);
        do_reset();
        drive(2'b11, 16'h0000, 16'h0000, 2'b01, 2'b00, 1'b0);
        tick();
        #1 chk("t5_post_rst_owner", {31'd0, r_owner}, RR ? 32'd0 : 32'd1);
        tick();
        drive(2'b00, 16'h0, 16'h0, 2'b00, 2'b00, 1'b1);
        tick();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            int k0, k1;
            k0 = $urandom_range(0, 7);
            k1 = $urandom_range(0, 7);
            drive(2'($urandom_range(0, 3)),
                  atab[(k0 < 3) ? 0 : (k0 < 6) ? 1 : (k0 - 4)],
                  atab[(k1 < 3) ? 0 : (k1 < 6) ? 1 : (k1 - 4)],
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
